// File: rtl/vote_sched_if.sv
// Engine-to-scheduler result channel: valid/ready handshake
// plus the per-sample classification and regression payloads.
interface vote_sched_if #(
    parameter int N_LABELS  = 10,
    parameter int RES_WIDTH = 16
);
    logic                          i_res_vld;
    logic                          o_res_rdy;
    logic [N_LABELS*RES_WIDTH-1:0] i_clf_accum;
    logic [RES_WIDTH-1:0]          i_rgs_accum;

    modport master (
        output i_res_vld,
        output i_clf_accum,
        output i_rgs_accum,
        input  o_res_rdy
    );

    modport slave (
        input  i_res_vld,
        input  i_clf_accum,
        input  i_rgs_accum,
        output o_res_rdy
    );
endinterface

// File: rtl/vote_sched.sv
// vote_sched: paces tree results into vote_buffer, marks tree
// boundaries, drains the accumulate pipe, then hands BRAM to the PS.
module vote_sched #(
    parameter int N_LABELS       = 10,
    parameter int N_LABELS_WIDTH = 4,
    parameter int RES_WIDTH      = 16,
    parameter int BRAM_AWIDTH    = 14,
    parameter int N_TREES_WIDTH  = 8,
    parameter int DRAIN_CYCLES   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [BRAM_AWIDTH-1:0]        i_n_samples,
    input  logic [N_TREES_WIDTH-1:0]      i_n_trees,
    input  logic [N_LABELS_WIDTH-1:0]     i_n_labels,
    input  logic                          i_is_clf,
    vote_sched_if.slave                   res,
    output logic [N_LABELS*RES_WIDTH-1:0] o_clf_accum,
    output logic [RES_WIDTH-1:0]          o_rgs_accum,
    output logic                          o_accum_vld,
    output logic                          o_vote_slot_rst,
    output logic [N_LABELS_WIDTH-1:0]     o_n_labels,
    output logic                          o_is_clf,
    output logic                          o_is_ps_read,
    input  logic                          i_ps_done,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [N_TREES_WIDTH-1:0]      o_tree_cnt
);

    localparam int GAP_W = N_LABELS_WIDTH + 1;
    localparam int TW1   = N_TREES_WIDTH + 1;
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int WT_W  = (DRN_W < 2) ? 2 : DRN_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_TREE_END,
        S_DRAIN,
        S_PS_READ,
        S_PS_HOLD
    } state_e;

    state_e                          state_q, state_d;
    logic [BRAM_AWIDTH-1:0]          n_smp_q, n_smp_d;
    logic [N_TREES_WIDTH-1:0]        n_trees_q, n_trees_d;
    logic [N_LABELS_WIDTH-1:0]       n_lbl_q, n_lbl_d;
    logic                            clf_mode_q, clf_mode_d;
    logic [BRAM_AWIDTH-1:0]          smp_q, smp_d;
    logic [N_TREES_WIDTH-1:0]        tree_q, tree_d;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic [2:0]                      te_q, te_d;
    logic [WT_W-1:0]                 wait_q, wait_d;
    logic                            srst_q, srst_d;
    logic                            vld_q;
    logic [N_LABELS*RES_WIDTH-1:0]   clf_q;
    logic [RES_WIDTH-1:0]            rgs_q;

    logic             rdy;
    logic             accept;
    logic             last_smp;
    logic             last_tree;
    logic [GAP_W-1:0] lbl_p1;
    logic [GAP_W-1:0] gap_load;

    assign rdy       = (state_q == S_RUN) && (gap_q == '0);
    assign accept    = rdy && res.i_res_vld;
    assign last_smp  = smp_q == (n_smp_q - BRAM_AWIDTH'(1));
    assign last_tree = (TW1'(tree_q) + TW1'(1)) >= TW1'(n_trees_q);

    // Counter holds gap-1, so ready returns exactly gap cycles later.
    assign lbl_p1   = GAP_W'(n_lbl_q) + GAP_W'(1);
    assign gap_load = !clf_mode_q ? '0 :
                      (lbl_p1 < GAP_W'(4)) ? GAP_W'(4) : lbl_p1;

    always_comb begin
        state_d    = state_q;
        n_smp_d    = n_smp_q;
        n_trees_d  = n_trees_q;
        n_lbl_d    = n_lbl_q;
        clf_mode_d = clf_mode_q;
        smp_d      = smp_q;
        tree_d     = tree_q;
        gap_d      = gap_q;
        te_d       = te_q;
        wait_d     = wait_q;
        srst_d     = 1'b0;

        if (gap_q != '0)
            gap_d = gap_q - GAP_W'(1);
        if (wait_q != '0)
            wait_d = wait_q - WT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    n_smp_d    = i_n_samples;
                    n_trees_d  = i_n_trees;
                    n_lbl_d    = i_n_labels;
                    clf_mode_d = i_is_clf;
                    smp_d      = '0;
                    tree_d     = '0;
                    gap_d      = '0;
                    if (i_n_samples == '0 || i_n_trees == '0) begin
                        state_d = S_DRAIN;
                        wait_d  = WT_W'(DRAIN_CYCLES - 1);
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    gap_d = gap_load;
                    if (last_smp) begin
                        state_d = S_TREE_END;
                        smp_d   = '0;
                        te_d    = '0;
                    end else begin
                        smp_d = smp_q + BRAM_AWIDTH'(1);
                    end
                end
            end
            S_TREE_END: begin
                if (te_q != 3'd4)
                    te_d = te_q + 3'd1;
                // Last tree skips the settle wait; drain covers it.
                if (te_q == 3'd0) begin
                    srst_d = 1'b1;
                    tree_d = tree_q + N_TREES_WIDTH'(1);
                    if (last_tree) begin
                        state_d = S_DRAIN;
                        wait_d  = WT_W'(DRAIN_CYCLES - 1);
                    end
                end else if (te_q == 3'd4 && gap_q <= GAP_W'(1)) begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (wait_q == '0)
                    state_d = S_PS_READ;
            end
            S_PS_READ: begin
                if (i_ps_done) begin
                    state_d = S_PS_HOLD;
                    wait_d  = WT_W'(2);
                end
            end
            S_PS_HOLD: begin
                if (wait_q == '0)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_smp_q    <= '0;
            n_trees_q  <= '0;
            n_lbl_q    <= '0;
            clf_mode_q <= 1'b0;
            smp_q      <= '0;
            tree_q     <= '0;
            gap_q      <= '0;
            te_q       <= '0;
            wait_q     <= '0;
            srst_q     <= 1'b0;
            vld_q      <= 1'b0;
            clf_q      <= '0;
            rgs_q      <= '0;
        end else begin
            state_q    <= state_d;
            n_smp_q    <= n_smp_d;
            n_trees_q  <= n_trees_d;
            n_lbl_q    <= n_lbl_d;
            clf_mode_q <= clf_mode_d;
            smp_q      <= smp_d;
            tree_q     <= tree_d;
            gap_q      <= gap_d;
            te_q       <= te_d;
            wait_q     <= wait_d;
            srst_q     <= srst_d;
            vld_q      <= accept;
            if (accept) begin
                clf_q <= res.i_clf_accum;
                rgs_q <= res.i_rgs_accum;
            end
        end
    end

    assign res.o_res_rdy   = rdy;
    assign o_clf_accum     = clf_q;
    assign o_rgs_accum     = rgs_q;
    assign o_accum_vld     = vld_q;
    assign o_vote_slot_rst = srst_q;
    assign o_n_labels      = n_lbl_q;
    assign o_is_clf        = clf_mode_q;
    assign o_is_ps_read    = (state_q == S_PS_READ) || (state_q == S_PS_HOLD);
    assign o_busy          = state_q != S_IDLE;
    assign o_done          = state_q == S_PS_READ;
    assign o_tree_cnt      = tree_q;

endmodule

// File: tb/tb_vote_sched.sv
// Directed bench for vote_sched: issue pacing, tree boundaries,
// drain/PS handover, config latching and asynchronous reset.
module tb_vote_sched;
    localparam int NL  = 10;
    localparam int NLW = 4;
    localparam int RW  = 16;
    localparam int AW  = 14;
    localparam int TW  = 8;
    localparam int DC  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_start;
    logic [AW-1:0]   i_n_samples;
    logic [TW-1:0]   i_n_trees;
    logic [NLW-1:0]  i_n_labels;
    logic            i_is_clf;
    logic [NL*RW-1:0] o_clf_accum;
    logic [RW-1:0]   o_rgs_accum;
    logic            o_accum_vld;
    logic            o_vote_slot_rst;
    logic [NLW-1:0]  o_n_labels;
    logic            o_is_clf;
    logic            o_is_ps_read;
    logic            i_ps_done;
    logic            o_busy;
    logic            o_done;
    logic [TW-1:0]   o_tree_cnt;

    vote_sched_if #(.N_LABELS(NL), .RES_WIDTH(RW)) bus ();

    vote_sched #(
        .N_LABELS(NL), .N_LABELS_WIDTH(NLW), .RES_WIDTH(RW),
        .BRAM_AWIDTH(AW), .N_TREES_WIDTH(TW), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_n_samples(i_n_samples), .i_n_trees(i_n_trees),
        .i_n_labels(i_n_labels), .i_is_clf(i_is_clf),
        .res(bus),
        .o_clf_accum(o_clf_accum), .o_rgs_accum(o_rgs_accum),
        .o_accum_vld(o_accum_vld), .o_vote_slot_rst(o_vote_slot_rst),
        .o_n_labels(o_n_labels), .o_is_clf(o_is_clf),
        .o_is_ps_read(o_is_ps_read), .i_ps_done(i_ps_done),
        .o_busy(o_busy), .o_done(o_done), .o_tree_cnt(o_tree_cnt)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int cyc = 0;

    int acc_cyc[$];
    int vld_cyc[$];
    int srst_cyc[$];
    logic [RW-1:0]    acc_rgs[$];
    logic [RW-1:0]    out_rgs[$];
    logic [NL*RW-1:0] acc_clf[$];
    logic [NL*RW-1:0] out_clf[$];
    int   psr_rise;
    logic psr_prev = 1'b0;
    bit   clf_unstable;
    bit   rdy_seen;
    logic [NL*RW-1:0] clf_last;

    always @(posedge clk) cyc <= cyc + 1;

    // Payload changes every cycle so held outputs are meaningful.
    always @(posedge clk) begin
        #1;
        bus.i_rgs_accum = 16'hA000 ^ cyc[15:0];
        for (int l = 0; l < NL; l++)
            bus.i_clf_accum[l*RW +: RW] = RW'(cyc * 16 + l);
    end

    always @(negedge clk) begin
        if (bus.i_res_vld && bus.o_res_rdy) begin
            acc_cyc.push_back(cyc);
            acc_rgs.push_back(bus.i_rgs_accum);
            acc_clf.push_back(bus.i_clf_accum);
        end
        if (o_accum_vld) begin
            vld_cyc.push_back(cyc);
            out_rgs.push_back(o_rgs_accum);
            out_clf.push_back(o_clf_accum);
        end else if (o_clf_accum !== clf_last) begin
            clf_unstable = 1'b1;
        end
        clf_last = o_clf_accum;
        if (o_vote_slot_rst) srst_cyc.push_back(cyc);
        if (o_is_ps_read && !psr_prev) psr_rise = cyc;
        psr_prev = o_is_ps_read;
        if (bus.o_res_rdy) rdy_seen = 1'b1;
    end

    task automatic clear_mon();
        acc_cyc.delete();
        vld_cyc.delete();
        srst_cyc.delete();
        acc_rgs.delete();
        out_rgs.delete();
        acc_clf.delete();
        out_clf.delete();
        psr_rise     = -1;
        clf_unstable = 1'b0;
        rdy_seen     = 1'b0;
        clf_last     = o_clf_accum;
    endtask

    task automatic start_job(input int ns, input int nt, input int nl,
                             input bit clf, output int s);
        @(posedge clk); #1;
        clear_mon();
        i_n_samples   = AW'(ns);
        i_n_trees     = TW'(nt);
        i_n_labels    = NLW'(nl);
        i_is_clf      = clf;
        i_start       = 1'b1;
        bus.i_res_vld = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic ps_release();
        @(posedge clk); #1;
        bus.i_res_vld = 1'b0;
        i_ps_done = 1'b1;
        @(posedge clk); #1;
        i_ps_done = 1'b0;
        for (int i = 0; i < 10 && o_busy; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({o_busy, bus.o_res_rdy, o_accum_vld, o_vote_slot_rst,
             o_is_ps_read, o_done, o_is_clf} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0", {o_busy,
                     bus.o_res_rdy, o_accum_vld, o_vote_slot_rst,
                     o_is_ps_read, o_done, o_is_clf});
        end
        n_checks++;
        if (o_tree_cnt !== 8'd0 || o_n_labels !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: tree %0d labels %0d required 0",
                     o_tree_cnt, o_n_labels);
        end
        n_checks++;
        if (o_rgs_accum !== '0 || o_clf_accum !== '0) begin
            n_fail++;
            $display("FAIL reset_data: rgs %h required 0", o_rgs_accum);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy %b required 0", o_busy);
        end
    endtask

    task automatic test_regression();
        int s;
        bit ok;
        int ev[8];
        start_job(4, 2, 3, 1'b0, s);
        ev = '{s+2, s+3, s+4, s+5, s+11, s+12, s+13, s+14};
        wait_done(200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rgs_timeout: o_done never rose, required within 200");
        end
        n_checks++;
        if (vld_cyc.size() != 8) begin
            n_fail++;
            $display("FAIL rgs_vld_count: got %0d required 8", vld_cyc.size());
        end
        for (int k = 0; k < 8 && k < vld_cyc.size(); k++) begin
            n_checks++;
            if (vld_cyc[k] != ev[k]) begin
                n_fail++;
                $display("FAIL rgs_vld_cycle[%0d]: got %0d required %0d",
                         k, vld_cyc[k] - s, ev[k] - s);
            end
            n_checks++;
            if (k < acc_rgs.size() && out_rgs[k] !== acc_rgs[k]) begin
                n_fail++;
                $display("FAIL rgs_data[%0d]: got %h required %h",
                         k, out_rgs[k], acc_rgs[k]);
            end
        end
        n_checks++;
        if (srst_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL rgs_srst_count: got %0d required 2", srst_cyc.size());
        end else if (srst_cyc[0] != s + 6 || srst_cyc[1] != s + 15) begin
            n_fail++;
            $display("FAIL rgs_srst_cycle: got %0d,%0d required 6,15",
                     srst_cyc[0] - s, srst_cyc[1] - s);
        end
        n_checks++;
        if (o_tree_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL rgs_tree_cnt: got %0d required 2", o_tree_cnt);
        end
        n_checks++;
        if (psr_rise != s + 23) begin
            n_fail++;
            $display("FAIL rgs_ps_read_rise: got %0d required %0d",
                     psr_rise - s, 23);
        end
        n_checks++;
        if (o_is_clf !== 1'b0 || o_n_labels !== 4'd3) begin
            n_fail++;
            $display("FAIL rgs_latched_cfg: clf %b labels %0d required 0,3",
                     o_is_clf, o_n_labels);
        end
    endtask

    task automatic test_ps_handover();
        @(posedge clk); #1;
        bus.i_res_vld = 1'b0;
        i_ps_done = 1'b1;
        @(posedge clk); #1;
        i_ps_done = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (o_is_ps_read !== 1'b1 || o_done !== 1'b0) begin
                n_fail++;
                $display("FAIL ps_hold[u+%0d]: ps_read %b done %b required 1,0",
                         k, o_is_ps_read, o_done);
            end
        end
        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0 || o_is_ps_read !== 1'b0) begin
            n_fail++;
            $display("FAIL ps_idle[u+4]: busy %b ps_read %b required 0,0",
                     o_busy, o_is_ps_read);
        end
    endtask

    task automatic test_clf_wide();
        int s;
        bit ok;
        start_job(3, 1, 10, 1'b1, s);
        wait_done(200, ok);
        n_checks++;
        if (!ok || acc_cyc.size() != 3) begin
            n_fail++;
            $display("FAIL clf10_count: done %b accepts %0d required 1,3",
                     ok, acc_cyc.size());
        end
        for (int k = 0; k < 3 && k < acc_cyc.size(); k++) begin
            n_checks++;
            if (acc_cyc[k] != s + 1 + 12 * k) begin
                n_fail++;
                $display("FAIL clf10_accept[%0d]: got %0d required %0d",
                         k, acc_cyc[k] - s, 1 + 12 * k);
            end
            n_checks++;
            if (k < out_clf.size() && out_clf[k] !== acc_clf[k]) begin
                n_fail++;
                $display("FAIL clf10_data[%0d]: got %h required %h",
                         k, out_clf[k], acc_clf[k]);
            end
        end
        n_checks++;
        if (clf_unstable) begin
            n_fail++;
            $display("FAIL clf10_hold: o_clf_accum moved between issues, required stable");
        end
        n_checks++;
        if (srst_cyc.size() != 1 || psr_rise != s + 35) begin
            n_fail++;
            $display("FAIL clf10_end: srst %0d ps_read at %0d required 1,35",
                     srst_cyc.size(), psr_rise - s);
        end
        ps_release();
    endtask

    task automatic test_clf_floor();
        int s;
        bit ok;
        int ea[4];
        start_job(2, 2, 2, 1'b1, s);
        ea = '{s+1, s+6, s+12, s+17};
        wait_done(200, ok);
        n_checks++;
        if (!ok || acc_cyc.size() != 4) begin
            n_fail++;
            $display("FAIL clf2_count: done %b accepts %0d required 1,4",
                     ok, acc_cyc.size());
        end
        for (int k = 0; k < 4 && k < acc_cyc.size(); k++) begin
            n_checks++;
            if (acc_cyc[k] != ea[k]) begin
                n_fail++;
                $display("FAIL clf2_accept[%0d]: got %0d required %0d",
                         k, acc_cyc[k] - s, ea[k] - s);
            end
        end
        n_checks++;
        if (psr_rise != s + 27 || o_tree_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL clf2_end: ps_read at %0d trees %0d required 27,2",
                     psr_rise - s, o_tree_cnt);
        end
        ps_release();
    endtask

    task automatic test_zero_trees();
        int s;
        bit ok;
        start_job(5, 0, 3, 1'b1, s);
        wait_done(50, ok);
        n_checks++;
        if (!ok || rdy_seen) begin
            n_fail++;
            $display("FAIL zero_rdy: done %b rdy_seen %b required 1,0",
                     ok, rdy_seen);
        end
        n_checks++;
        if (psr_rise != s + 9) begin
            n_fail++;
            $display("FAIL zero_ps_read_rise: got %0d required 9", psr_rise - s);
        end
        n_checks++;
        if (vld_cyc.size() != 0 || srst_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL zero_activity: vld %0d srst %0d required 0,0",
                     vld_cyc.size(), srst_cyc.size());
        end
        ps_release();
    endtask

    task automatic test_restart_ignored();
        int s;
        bit ok;
        start_job(2, 1, 4, 1'b1, s);
        @(posedge clk); #1;
        i_start     = 1'b1;
        i_ps_done   = 1'b1;
        i_n_labels  = 4'd7;
        i_is_clf    = 1'b0;
        i_n_samples = 14'd9;
        i_n_trees   = 8'd5;
        @(posedge clk); #1;
        i_start   = 1'b0;
        i_ps_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_n_labels !== 4'd4 || o_is_clf !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_cfg: labels %0d clf %b required 4,1",
                     o_n_labels, o_is_clf);
        end
        wait_done(200, ok);
        n_checks++;
        if (!ok || acc_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL restart_count: done %b accepts %0d required 1,2",
                     ok, acc_cyc.size());
        end else if (acc_cyc[1] - acc_cyc[0] != 6) begin
            n_fail++;
            $display("FAIL restart_gap: got %0d required 6",
                     acc_cyc[1] - acc_cyc[0]);
        end
        n_checks++;
        if (psr_rise != s + 17 || o_tree_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL restart_end: ps_read at %0d trees %0d required 17,1",
                     psr_rise - s, o_tree_cnt);
        end
        ps_release();
    endtask

    task automatic test_reset_mid();
        int s;
        bit ok;
        start_job(2, 3, 5, 1'b0, s);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (o_busy !== 1'b1 || o_tree_cnt !== 8'd1 || o_rgs_accum === '0) begin
            n_fail++;
            $display("FAIL mid_pre: busy %b trees %0d required 1,1",
                     o_busy, o_tree_cnt);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({o_busy, bus.o_res_rdy, o_accum_vld, o_vote_slot_rst,
             o_is_ps_read, o_done, o_is_clf} !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_rst_flags: got %b required 0", {o_busy,
                     bus.o_res_rdy, o_accum_vld, o_vote_slot_rst,
                     o_is_ps_read, o_done, o_is_clf});
        end
        n_checks++;
        if (o_tree_cnt !== 8'd0 || o_n_labels !== 4'd0 ||
            o_rgs_accum !== '0 || o_clf_accum !== '0) begin
            n_fail++;
            $display("FAIL mid_rst_regs: trees %0d labels %0d rgs %h required 0",
                     o_tree_cnt, o_n_labels, o_rgs_accum);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        start_job(3, 2, 1, 1'b0, s);
        wait_done(200, ok);
        n_checks++;
        if (!ok || vld_cyc.size() != 6) begin
            n_fail++;
            $display("FAIL mid_rerun_count: done %b issues %0d required 1,6",
                     ok, vld_cyc.size());
        end
        n_checks++;
        if (acc_cyc.size() != 6 || acc_cyc[3] != s + 9) begin
            n_fail++;
            $display("FAIL mid_rerun_tree2: accepts %0d required 6 with tree 2 at 9",
                     acc_cyc.size());
        end
        n_checks++;
        if (psr_rise != s + 21 || o_tree_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL mid_rerun_end: ps_read at %0d trees %0d required 21,2",
                     psr_rise - s, o_tree_cnt);
        end
        ps_release();
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        i_start         = 1'b0;
        i_ps_done       = 1'b0;
        i_n_samples     = '0;
        i_n_trees       = '0;
        i_n_labels      = '0;
        i_is_clf        = 1'b0;
        bus.i_res_vld   = 1'b0;
        bus.i_rgs_accum = '0;
        bus.i_clf_accum = '0;
        psr_rise        = -1;
        test_reset();
        test_regression();
        test_ps_handover();
        test_clf_wide();
        test_clf_floor();
        test_zero_trees();
        test_restart_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vote_sched.md
# vote_sched

Sequencer in front of `vote_buffer`. It accepts per-sample tree results from the tree-evaluation engine over a valid/ready handshake and spaces them to the vote datapath's minimum issue intervals. It issues the vote-slot reset at every tree boundary, drains the accumulate pipeline after the last tree, and then hands the vote BRAM to the PS for clear-on-read readout.

## Interface
Parameters:
- `N_LABELS`, 10, maximum label count
- `N_LABELS_WIDTH`, 4, label count width
- `RES_WIDTH`, 16, result width
- `BRAM_AWIDTH`, 14, vote slot / sample count width
- `N_TREES_WIDTH`, 8, tree count width
- `DRAIN_CYCLES`, 8, idle cycles after the last result before PS handover

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `i_start`  in  1  start pulse; sampled only in IDLE
- `i_n_samples`  in  BRAM_AWIDTH  samples per tree
- `i_n_trees`  in  N_TREES_WIDTH  trees per job
- `i_n_labels`  in  N_LABELS_WIDTH  label count
- `i_is_clf`  in  1  1 = classification, 0 = regression
- `i_res_vld`  in  1  engine result valid
- `o_res_rdy`  out  1  result accepted when `i_res_vld & o_res_rdy`
- `i_clf_accum`  in  N_LABELS*RES_WIDTH  classification result
- `i_rgs_accum`  in  RES_WIDTH  regression result
- `o_clf_accum`  out  N_LABELS*RES_WIDTH  registered result to `vote_buffer`
- `o_rgs_accum`  out  RES_WIDTH  registered result to `vote_buffer`
- `o_accum_vld`  out  1  one-cycle issue strobe to `vote_buffer`
- `o_vote_slot_rst`  out  1  one-cycle vote-slot counter clear
- `o_n_labels`  out  N_LABELS_WIDTH  latched label count
- `o_is_clf`  out  1  latched mode
- `o_is_ps_read`  out  1  vote BRAM owned by PS
- `i_ps_done`  in  1  PS readout finished (pulse)
- `o_busy`  out  1  state != IDLE
- `o_done`  out  1  high while in PS_READ
- `o_tree_cnt`  out  N_TREES_WIDTH  trees completed in the current job

## Operation
- On `i_start` in IDLE, latch `i_n_samples`, `i_n_trees`, `i_n_labels` and `i_is_clf`, and clear the sample and tree counters.
  - If either count is 0, go to DRAIN.
  - Otherwise go to RUN.
- States and transitions:
  - IDLE -> RUN or DRAIN on `i_start`.
  - RUN -> TREE_END on acceptance of sample `n_samples-1`.
  - TREE_END -> RUN once the settle time expires and `tree_cnt < n_trees`; otherwise TREE_END -> DRAIN.
  - DRAIN -> PS_READ after `DRAIN_CYCLES`.
  - PS_READ -> PS_HOLD on `i_ps_done`.
  - PS_HOLD -> IDLE after 3 cycles.
- `o_res_rdy` = (state == RUN) & (gap counter == 0). It is combinational from registers and never depends on `i_res_vld`.
- On acceptance:
  - Register the result into `o_clf_accum`/`o_rgs_accum`. The registers hold until the next acceptance, because `vote_buffer` scans the classification labels over several cycles.
  - Increment the sample counter.
  - Load the gap counter.
- Gap values:
  - Classification: max(5, `o_n_labels`+2).
  - Regression: 1. Back-to-back is allowed within a tree because consecutive results go to different slots.
- TREE_END:
  - `o_vote_slot_rst` pulses exactly once, 2 cycles after the last acceptance.
  - `tree_cnt` increments in the same cycle as that pulse.
  - The state stays in TREE_END until 4 cycles after the pulse and until the gap counter reaches 0.
  - The sample counter resets to 0 there.
- DRAIN: a cycle counter runs down from `DRAIN_CYCLES`. `o_is_ps_read` stays 0.
- PS_READ: `o_is_ps_read`=1 and `o_done`=1. `i_res_vld` is ignored.
- PS_HOLD: `o_is_ps_read` stays 1 so the 2-stage clear-on-read pipeline in `vote_buffer` completes. `o_done`=0.
- Counters:
  - The sample counter is `BRAM_AWIDTH` wide and never wraps; the terminal compare happens first.
  - `tree_cnt` is `N_TREES_WIDTH` wide.
- `i_start` outside IDLE is ignored. `i_ps_done` outside PS_READ is ignored.

## Timing
- Reset state (asynchronous assert): IDLE, all counters 0.
  - All outputs 0: `o_res_rdy`, `o_accum_vld`, `o_vote_slot_rst`, `o_is_ps_read`, `o_busy`, `o_done`, `o_tree_cnt`, data outputs, `o_n_labels`, `o_is_clf`.
  - Reset mid-job aborts immediately. The next job must start from a PS-cleared buffer; clearing it is software's responsibility.
- `i_start` at cycle t: `o_busy`=1 at t+1, and `o_res_rdy` can first be 1 at t+1.
- Acceptance at cycle t:
  - `o_accum_vld`=1 and data are valid at t+1.
  - `o_res_rdy`=0 for gap-1 cycles after t. Regression therefore sustains 1 result/cycle.
- Last sample accepted at t:
  - `o_vote_slot_rst` pulses at t+2.
  - The next tree's first result can be accepted no earlier than max(t+6, t+gap).
- Last result of the job issued at t+1:
  - `o_is_ps_read`=1 and `o_done`=1 at t+1+`DRAIN_CYCLES`+1.
- `i_ps_done` at cycle u: `o_is_ps_read` stays 1 through u+3, and IDLE is reached at u+4.

## Test plan
- Regression, `n_samples`=4, `n_trees`=2, `i_res_vld` held high:
  - `o_accum_vld` is high for 4 consecutive cycles per tree.
  - `o_vote_slot_rst` pulses twice, each 2 cycles after the 4th acceptance.
  - The second tree's first `o_accum_vld` comes at least 6 cycles after the first tree's last acceptance.
  - `o_tree_cnt` ends at 2.
- Classification, `n_labels`=10, `n_samples`=3: acceptances are spaced exactly 12 cycles apart, and `o_clf_accum` is stable between them.
- Classification, `n_labels`=2: spacing is 5 cycles (floor applied).
- End of job: `o_is_ps_read` rises `DRAIN_CYCLES`+1 cycles after the final `o_accum_vld`. After an `i_ps_done` pulse it stays high 3 more cycles, then `o_busy`=0.
- `n_trees`=0 start: no `o_res_rdy`, direct DRAIN then PS_READ. A second `i_start` during RUN does not change the latched config.
- `rst` asserted during TREE_END: all outputs are 0 in the same cycle. After release, a new `i_start` runs a full job correctly.
